// File: rtl/fast_vram_ctrl.sv
// Arbiter and sequencer for the 2048x16 fast VRAM pair.
// The LSPC render port and the CPU register port share one set of registered SRAM strobes.
module fast_vram_ctrl #(
    parameter int RD_CYC     = 1,
    parameter int WR_CYC     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        REN_REQ,
    input  logic [10:0] REN_ADDR,
    output logic        REN_ACK,
    output logic [15:0] REN_RDATA,
    input  logic        CPU_ADDR_LD,
    input  logic [10:0] CPU_ADDR_IN,
    input  logic [10:0] CPU_MOD,
    input  logic        CPU_REQ,
    input  logic        CPU_WR,
    input  logic [15:0] CPU_WDATA,
    output logic        CPU_ACK,
    output logic [15:0] CPU_RDATA,
    output logic [10:0] CPU_ADDR,
    output logic [10:0] VRAM_ADDR,
    output logic [15:0] VRAM_DOUT,
    output logic        VRAM_DOE,
    input  logic [15:0] VRAM_DIN,
    output logic        VRAM_nCE,
    output logic        VRAM_nOE,
    output logic        VRAM_nWE
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        WR_HOLD
    } state_t;

    localparam logic [3:0] RD_LAST    = 4'(RD_CYC);
    localparam logic [3:0] WR_LAST    = 4'(WR_CYC - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    logic [3:0]  cyc_cnt;
    logic [3:0]  starve_cnt;
    logic        cpu_owner;
    logic [10:0] cpu_addr_nxt;
    logic        ren_grant;
    logic        cpu_grant;

    // A grant in the CPU ACK cycle must already see the post-increment (or reloaded) address.
    always_comb begin
        cpu_addr_nxt = CPU_ADDR;
        if (CPU_ADDR_LD) begin
            cpu_addr_nxt = CPU_ADDR_IN;
        end else if (CPU_ACK) begin
            cpu_addr_nxt = CPU_ADDR + CPU_MOD;
        end
    end

    always_comb begin
        ren_grant = REN_REQ && !(CPU_REQ && (starve_cnt == STARVE_LIM));
        cpu_grant = CPU_REQ && !ren_grant;
    end

    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            starve_cnt <= '0;
            cpu_owner  <= 1'b0;
            REN_ACK    <= 1'b0;
            REN_RDATA  <= '0;
            CPU_ACK    <= 1'b0;
            CPU_RDATA  <= '0;
            CPU_ADDR   <= '0;
            VRAM_ADDR  <= '0;
            VRAM_DOUT  <= '0;
            VRAM_DOE   <= 1'b0;
            VRAM_nCE   <= 1'b1;
            VRAM_nOE   <= 1'b1;
            VRAM_nWE   <= 1'b1;
        end else begin
            REN_ACK  <= 1'b0;
            CPU_ACK  <= 1'b0;
            CPU_ADDR <= cpu_addr_nxt;
            case (state)
                IDLE: begin
                    if (ren_grant) begin
                        state      <= RD;
                        cpu_owner  <= 1'b0;
                        cyc_cnt    <= '0;
                        VRAM_ADDR  <= REN_ADDR;
                        VRAM_nCE   <= 1'b0;
                        VRAM_nOE   <= 1'b0;
                        starve_cnt <= CPU_REQ ? starve_cnt + 4'd1 : 4'd0;
                    end else if (cpu_grant) begin
                        cpu_owner  <= 1'b1;
                        cyc_cnt    <= '0;
                        starve_cnt <= '0;
                        VRAM_ADDR  <= cpu_addr_nxt;
                        VRAM_nCE   <= 1'b0;
                        if (CPU_WR) begin
                            state     <= WR;
                            VRAM_DOUT <= CPU_WDATA;
                            VRAM_DOE  <= 1'b1;
                            VRAM_nWE  <= 1'b0;
                        end else begin
                            state    <= RD;
                            VRAM_nOE <= 1'b0;
                        end
                    end
                end
                // The grant cycle settles the address; data is sampled after RD_CYC further strobe cycles.
                RD: begin
                    if (cyc_cnt == RD_LAST) begin
                        state    <= IDLE;
                        VRAM_nCE <= 1'b1;
                        VRAM_nOE <= 1'b1;
                        if (cpu_owner) begin
                            CPU_RDATA <= VRAM_DIN;
                            CPU_ACK   <= 1'b1;
                        end else begin
                            REN_RDATA <= VRAM_DIN;
                            REN_ACK   <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 4'd1;
                    end
                end
                WR: begin
                    if (cyc_cnt == WR_LAST) begin
                        state    <= WR_HOLD;
                        VRAM_nWE <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 4'd1;
                    end
                end
                WR_HOLD: begin
                    state    <= IDLE;
                    VRAM_nCE <= 1'b1;
                    VRAM_DOE <= 1'b0;
                    CPU_ACK  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    VRAM_nCE <= 1'b1;
                    VRAM_nOE <= 1'b1;
                    VRAM_nWE <= 1'b1;
                    VRAM_DOE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fast_vram_ctrl.sv
// Self-checking bench for fast_vram_ctrl: SRAM model, expected-memory/address reference model,
// directed scenarios plus randomized transactions and a free-running bus protocol monitor.
module tb_fast_vram_ctrl;

    localparam int RD_CYC     = 1;
    localparam int WR_CYC     = 1;
    localparam int STARVE_MAX = 4;
    localparam int RD_LAT     = RD_CYC + 2;
    localparam int WR_LAT     = WR_CYC + 2;
    localparam int ACK_PERIOD = RD_CYC + 2;
    localparam int BUDGET     = 40;

    logic        CLK_24M = 1'b0;
    logic        nRESET;
    logic        REN_REQ;
    logic [10:0] REN_ADDR;
    logic        REN_ACK;
    logic [15:0] REN_RDATA;
    logic        CPU_ADDR_LD;
    logic [10:0] CPU_ADDR_IN;
    logic [10:0] CPU_MOD;
    logic        CPU_REQ;
    logic        CPU_WR;
    logic [15:0] CPU_WDATA;
    logic        CPU_ACK;
    logic [15:0] CPU_RDATA;
    logic [10:0] CPU_ADDR;
    logic [10:0] VRAM_ADDR;
    logic [15:0] VRAM_DOUT;
    logic        VRAM_DOE;
    logic [15:0] VRAM_DIN;
    logic        VRAM_nCE;
    logic        VRAM_nOE;
    logic        VRAM_nWE;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram    [2048];
    logic [15:0] exp_mem [2048];
    logic [10:0] exp_cpu_addr;
    logic [15:0] mem_seed;
    logic        fill_req  = 1'b0;
    logic        poke_en   = 1'b0;
    logic [10:0] poke_addr = '0;
    logic [15:0] poke_data = '0;

    always #5 CLK_24M = ~CLK_24M;

    fast_vram_ctrl #(
        .RD_CYC    (RD_CYC),
        .WR_CYC    (WR_CYC),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK_24M    (CLK_24M),
        .nRESET     (nRESET),
        .REN_REQ    (REN_REQ),
        .REN_ADDR   (REN_ADDR),
        .REN_ACK    (REN_ACK),
        .REN_RDATA  (REN_RDATA),
        .CPU_ADDR_LD(CPU_ADDR_LD),
        .CPU_ADDR_IN(CPU_ADDR_IN),
        .CPU_MOD    (CPU_MOD),
        .CPU_REQ    (CPU_REQ),
        .CPU_WR     (CPU_WR),
        .CPU_WDATA  (CPU_WDATA),
        .CPU_ACK    (CPU_ACK),
        .CPU_RDATA  (CPU_RDATA),
        .CPU_ADDR   (CPU_ADDR),
        .VRAM_ADDR  (VRAM_ADDR),
        .VRAM_DOUT  (VRAM_DOUT),
        .VRAM_DOE   (VRAM_DOE),
        .VRAM_DIN   (VRAM_DIN),
        .VRAM_nCE   (VRAM_nCE),
        .VRAM_nOE   (VRAM_nOE),
        .VRAM_nWE   (VRAM_nWE)
    );

    function automatic logic [15:0] fill_value(input int i);
        logic [31:0] t;
        t = i * 32'd40503;
        return t[15:0] ^ mem_seed;
    endfunction

    // Asynchronous SRAM: drives junk unless selected and output-enabled, stores while nCE/nWE are low.
    assign VRAM_DIN = (!VRAM_nCE && !VRAM_nOE) ? sram[VRAM_ADDR] : 16'hDEAD;

    always @(posedge CLK_24M) begin
        if (fill_req) begin
            for (int i = 0; i < 2048; i++) sram[i] <= fill_value(i);
        end else if (poke_en) begin
            sram[poke_addr] <= poke_data;
        end else if (!VRAM_nCE && !VRAM_nWE) begin
            sram[VRAM_ADDR] <= VRAM_DOUT;
        end
    end

    task automatic tick;
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic wait_ack(input bit cpu, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(cpu ? CPU_ACK : REN_ACK) && cycles <= BUDGET);
    endtask

    task automatic protocol_monitor;
        logic [10:0] we_addr;
        bit we_seen;
        we_seen = 1'b0;
        we_addr = '0;
        forever begin
            @(negedge CLK_24M);
            checks++;
            if (!VRAM_nOE && !VRAM_nWE) begin
                errors++;
                $display("[TB] FAIL proto_oe_we: nOE=%b nWE=%b, required not both low", VRAM_nOE, VRAM_nWE);
            end
            checks++;
            if (VRAM_DOE && !VRAM_nOE) begin
                errors++;
                $display("[TB] FAIL proto_doe: DOE=%b nOE=%b, required nOE=1 while DOE=1", VRAM_DOE, VRAM_nOE);
            end
            if (!VRAM_nWE) begin
                if (!we_seen) begin
                    we_addr = VRAM_ADDR;
                end else begin
                    checks++;
                    if (VRAM_ADDR !== we_addr) begin
                        errors++;
                        $display("[TB] FAIL proto_addr_we: addr=%h, required %h", VRAM_ADDR, we_addr);
                    end
                end
                we_seen = 1'b1;
            end else if (we_seen) begin
                checks++;
                if (VRAM_ADDR !== we_addr) begin
                    errors++;
                    $display("[TB] FAIL proto_addr_hold: addr=%h, required %h", VRAM_ADDR, we_addr);
                end
                we_seen = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        int diffs;
        nRESET = 1'b0;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        tick();
        checks++;
        if ({VRAM_nCE, VRAM_nOE, VRAM_nWE, VRAM_DOE} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reset_strobes: nCE/nOE/nWE/DOE=%b, required 1110", {VRAM_nCE, VRAM_nOE, VRAM_nWE, VRAM_DOE});
        end
        checks++;
        if (CPU_ADDR !== 11'h000 || VRAM_ADDR !== 11'h000 || VRAM_DOUT !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_addr: CPU_ADDR=%h VRAM_ADDR=%h DOUT=%h, required 0", CPU_ADDR, VRAM_ADDR, VRAM_DOUT);
        end
        checks++;
        if ({REN_ACK, CPU_ACK} !== 2'b00 || REN_RDATA !== 16'h0 || CPU_RDATA !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_port: acks=%b ren=%h cpu=%h, required 0", {REN_ACK, CPU_ACK}, REN_RDATA, CPU_RDATA);
        end
        nRESET = 1'b1;
        tick();
        diffs = 0;
        for (int i = 0; i < 2048; i++) if (sram[i] !== exp_mem[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            errors++;
            $display("[TB] FAIL reset_ram: %0d words differ, required 0", diffs);
        end
        // Reset in the middle of a render read must abort it cleanly.
        REN_ADDR = 11'h123;
        REN_REQ = 1'b1;
        tick();
        checks++;
        if (VRAM_nCE !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_start: nCE=%b, required 0", VRAM_nCE);
        end
        nRESET = 1'b0;
        tick();
        REN_REQ = 1'b0;
        checks++;
        if ({VRAM_nCE, VRAM_nOE, REN_ACK} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_mid_abort: nCE/nOE/REN_ACK=%b, required 110", {VRAM_nCE, VRAM_nOE, REN_ACK});
        end
        nRESET = 1'b1;
        tick();
        tick();
        checks++;
        if (REN_ACK !== 1'b0 || VRAM_nCE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_after: REN_ACK=%b nCE=%b, required 0/1", REN_ACK, VRAM_nCE);
        end
        exp_cpu_addr = 11'h000;
    endtask

    task automatic test_cpu_write;
        CPU_ADDR_LD = 1'b1;
        CPU_ADDR_IN = 11'h010;
        tick();
        CPU_ADDR_LD = 1'b0;
        exp_cpu_addr = 11'h010;
        checks++;
        if (CPU_ADDR !== 11'h010) begin
            errors++;
            $display("[TB] FAIL wr_load: CPU_ADDR=%h, required 010", CPU_ADDR);
        end
        CPU_MOD = 11'd1;
        CPU_WR = 1'b1;
        CPU_WDATA = 16'hBEEF;
        CPU_REQ = 1'b1;
        tick();
        checks++;
        if ({VRAM_nCE, VRAM_nOE, VRAM_nWE, VRAM_DOE} !== 4'b0101 || VRAM_ADDR !== 11'h010 || VRAM_DOUT !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL wr_strobe: nCE/nOE/nWE/DOE=%b addr=%h dout=%h, required 0101 010 beef",
                     {VRAM_nCE, VRAM_nOE, VRAM_nWE, VRAM_DOE}, VRAM_ADDR, VRAM_DOUT);
        end
        tick();
        checks++;
        if ({VRAM_nCE, VRAM_nOE, VRAM_nWE, VRAM_DOE, CPU_ACK} !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL wr_hold: nCE/nOE/nWE/DOE/ACK=%b, required 01110", {VRAM_nCE, VRAM_nOE, VRAM_nWE, VRAM_DOE, CPU_ACK});
        end
        tick();
        checks++;
        if ({CPU_ACK, VRAM_DOE, VRAM_nCE} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL wr_ack: ACK/DOE/nCE=%b, required 101", {CPU_ACK, VRAM_DOE, VRAM_nCE});
        end
        CPU_REQ = 1'b0;
        exp_mem[11'h010] = 16'hBEEF;
        exp_cpu_addr = 11'((int'(exp_cpu_addr) + 1) % 2048);
        tick();
        checks++;
        if (CPU_ADDR !== exp_cpu_addr || CPU_ACK !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_incr: CPU_ADDR=%h ACK=%b, required %h 0", CPU_ADDR, CPU_ACK, exp_cpu_addr);
        end
        checks++;
        if (sram[11'h010] !== exp_mem[11'h010]) begin
            errors++;
            $display("[TB] FAIL wr_ram: RAM[010]=%h, required %h", sram[11'h010], exp_mem[11'h010]);
        end
    endtask

    task automatic test_render_read;
        int cyc;
        poke_en = 1'b1;
        poke_addr = 11'h7FF;
        poke_data = 16'h1234;
        tick();
        poke_en = 1'b0;
        exp_mem[11'h7FF] = 16'h1234;
        REN_ADDR = 11'h7FF;
        REN_REQ = 1'b1;
        wait_ack(1'b0, cyc);
        REN_REQ = 1'b0;
        checks++;
        if (cyc != RD_LAT) begin
            errors++;
            $display("[TB] FAIL ren_latency: %0d cycles, required %0d", cyc, RD_LAT);
        end
        checks++;
        if (REN_RDATA !== exp_mem[11'h7FF]) begin
            errors++;
            $display("[TB] FAIL ren_data: %h, required %h", REN_RDATA, exp_mem[11'h7FF]);
        end
        tick();
        checks++;
        if (REN_ACK !== 1'b0 || REN_RDATA !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL ren_pulse: ACK=%b data=%h, required 0 1234", REN_ACK, REN_RDATA);
        end
    endtask

    task automatic test_wrap_load;
        int cyc;
        CPU_ADDR_LD = 1'b1;
        CPU_ADDR_IN = 11'h7FF;
        tick();
        CPU_ADDR_LD = 1'b0;
        exp_cpu_addr = 11'h7FF;
        CPU_MOD = 11'd2;
        CPU_WR = 1'b0;
        CPU_REQ = 1'b1;
        wait_ack(1'b1, cyc);
        CPU_REQ = 1'b0;
        checks++;
        if (cyc != RD_LAT || CPU_RDATA !== exp_mem[11'h7FF]) begin
            errors++;
            $display("[TB] FAIL wrap_read: cycles=%0d data=%h, required %0d %h", cyc, CPU_RDATA, RD_LAT, exp_mem[11'h7FF]);
        end
        exp_cpu_addr = 11'((int'(exp_cpu_addr) + 2) % 2048);
        tick();
        checks++;
        if (CPU_ADDR !== exp_cpu_addr) begin
            errors++;
            $display("[TB] FAIL wrap_addr: CPU_ADDR=%h, required %h", CPU_ADDR, exp_cpu_addr);
        end
        // Load presented in the ACK cycle must beat the increment.
        CPU_REQ = 1'b1;
        wait_ack(1'b1, cyc);
        CPU_REQ = 1'b0;
        CPU_ADDR_LD = 1'b1;
        CPU_ADDR_IN = 11'h100;
        checks++;
        if (CPU_RDATA !== exp_mem[exp_cpu_addr]) begin
            errors++;
            $display("[TB] FAIL wrap_read2: data=%h, required %h", CPU_RDATA, exp_mem[exp_cpu_addr]);
        end
        exp_cpu_addr = 11'h100;
        tick();
        CPU_ADDR_LD = 1'b0;
        checks++;
        if (CPU_ADDR !== exp_cpu_addr) begin
            errors++;
            $display("[TB] FAIL load_priority: CPU_ADDR=%h, required %h", CPU_ADDR, exp_cpu_addr);
        end
        // A load while the access is in flight leaves that access alone.
        CPU_REQ = 1'b1;
        tick();
        CPU_ADDR_LD = 1'b1;
        CPU_ADDR_IN = 11'h200;
        tick();
        CPU_ADDR_LD = 1'b0;
        tick();
        checks++;
        if (CPU_ACK !== 1'b1 || CPU_RDATA !== exp_mem[11'h100]) begin
            errors++;
            $display("[TB] FAIL inflight_read: ACK=%b data=%h, required 1 %h", CPU_ACK, CPU_RDATA, exp_mem[11'h100]);
        end
        CPU_REQ = 1'b0;
        exp_cpu_addr = 11'h202;
        tick();
        checks++;
        if (CPU_ADDR !== exp_cpu_addr) begin
            errors++;
            $display("[TB] FAIL inflight_addr: CPU_ADDR=%h, required %h", CPU_ADDR, exp_cpu_addr);
        end
    endtask

    task automatic test_starvation;
        logic [10:0] ra;
        int t = 0;
        int last_t = -1;
        int ren_before = 0;
        int ren_after = 0;
        int bad_gap = 0;
        int bad_data = 0;
        bit cpu_done = 1'b0;
        ra = 11'($urandom);
        REN_ADDR = ra;
        CPU_MOD = 11'd3;
        CPU_WR = 1'b0;
        REN_REQ = 1'b1;
        CPU_REQ = 1'b1;
        while (ren_after < 2 && t < 3 * BUDGET) begin
            tick();
            t++;
            if (REN_ACK) begin
                if (REN_RDATA !== exp_mem[ra]) bad_data++;
                if (last_t >= 0 && t - last_t != ACK_PERIOD) bad_gap++;
                last_t = t;
                if (cpu_done) ren_after++;
                else ren_before++;
                if (ren_after == 2) REN_REQ = 1'b0;
            end
            if (CPU_ACK) begin
                checks++;
                if (CPU_RDATA !== exp_mem[exp_cpu_addr]) begin
                    errors++;
                    $display("[TB] FAIL starve_cpu_data: %h, required %h", CPU_RDATA, exp_mem[exp_cpu_addr]);
                end
                exp_cpu_addr = 11'((int'(exp_cpu_addr) + 3) % 2048);
                CPU_REQ = 1'b0;
                if (last_t >= 0 && t - last_t != ACK_PERIOD) bad_gap++;
                last_t = t;
                cpu_done = 1'b1;
            end
        end
        REN_REQ = 1'b0;
        CPU_REQ = 1'b0;
        checks++;
        if (ren_before != STARVE_MAX || !cpu_done || ren_after != 2) begin
            errors++;
            $display("[TB] FAIL starve_order: render before cpu=%0d cpu_done=%0d after=%0d, required %0d 1 2",
                     ren_before, cpu_done, ren_after, STARVE_MAX);
        end
        checks++;
        if (bad_gap != 0 || bad_data != 0) begin
            errors++;
            $display("[TB] FAIL starve_stream: bad gaps=%0d bad data=%0d, required 0 0", bad_gap, bad_data);
        end
        tick();
        tick();
        checks++;
        if (CPU_ADDR !== exp_cpu_addr || {REN_ACK, CPU_ACK} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL starve_end: CPU_ADDR=%h acks=%b, required %h 00", CPU_ADDR, {REN_ACK, CPU_ACK}, exp_cpu_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] base;
        logic [15:0] d [3];
        int cyc;
        int diffs = 0;
        base = 11'($urandom_range(0, 2047));
        for (int k = 0; k < 3; k++) d[k] = 16'($urandom);
        CPU_ADDR_LD = 1'b1;
        CPU_ADDR_IN = base;
        tick();
        CPU_ADDR_LD = 1'b0;
        exp_cpu_addr = base;
        CPU_MOD = 11'd1;
        CPU_WR = 1'b1;
        CPU_WDATA = d[0];
        CPU_REQ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b1, cyc);
            checks++;
            if (cyc != WR_LAT) begin
                errors++;
                $display("[TB] FAIL b2b_period%0d: %0d cycles, required %0d", k, cyc, WR_LAT);
            end
            exp_mem[exp_cpu_addr] = d[k];
            exp_cpu_addr = 11'((int'(exp_cpu_addr) + 1) % 2048);
            if (k < 2) CPU_WDATA = d[k + 1];
            else CPU_REQ = 1'b0;
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            if (sram[11'((int'(base) + k) % 2048)] !== d[k]) diffs++;
        end
        checks++;
        if (diffs != 0 || CPU_ADDR !== exp_cpu_addr) begin
            errors++;
            $display("[TB] FAIL b2b_result: %0d bad words, CPU_ADDR=%h, required 0 %h", diffs, CPU_ADDR, exp_cpu_addr);
        end
    endtask

    task automatic test_random;
        logic [10:0] a;
        logic [10:0] mod;
        logic [15:0] data;
        logic [10:0] last_wr = '0;
        bit wr;
        int cyc;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? last_wr : 11'($urandom);
                REN_ADDR = a;
                REN_REQ = 1'b1;
                wait_ack(1'b0, cyc);
                REN_REQ = 1'b0;
                checks++;
                if (cyc != RD_LAT || REN_RDATA !== exp_mem[a]) begin
                    errors++;
                    $display("[TB] FAIL rnd_ren%0d: cycles=%0d data=%h, required %0d %h", n, cyc, REN_RDATA, RD_LAT, exp_mem[a]);
                end
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    a = 11'($urandom);
                    CPU_ADDR_LD = 1'b1;
                    CPU_ADDR_IN = a;
                    tick();
                    CPU_ADDR_LD = 1'b0;
                    exp_cpu_addr = a;
                end
                a = exp_cpu_addr;
                mod = 11'($urandom);
                wr = 1'($urandom_range(0, 1));
                data = 16'($urandom);
                CPU_MOD = mod;
                CPU_WR = wr;
                CPU_WDATA = data;
                CPU_REQ = 1'b1;
                wait_ack(1'b1, cyc);
                CPU_REQ = 1'b0;
                checks++;
                if (cyc != (wr ? WR_LAT : RD_LAT)) begin
                    errors++;
                    $display("[TB] FAIL rnd_cpu_lat%0d: %0d cycles, required %0d", n, cyc, wr ? WR_LAT : RD_LAT);
                end
                if (wr) begin
                    exp_mem[a] = data;
                    last_wr = a;
                end else begin
                    checks++;
                    if (CPU_RDATA !== exp_mem[a]) begin
                        errors++;
                        $display("[TB] FAIL rnd_cpu_rd%0d: %h, required %h", n, CPU_RDATA, exp_mem[a]);
                    end
                end
                exp_cpu_addr = 11'((int'(a) + int'(mod)) % 2048);
                tick();
                checks++;
                if (CPU_ADDR !== exp_cpu_addr || sram[a] !== exp_mem[a]) begin
                    errors++;
                    $display("[TB] FAIL rnd_cpu_post%0d: CPU_ADDR=%h RAM=%h, required %h %h",
                             n, CPU_ADDR, sram[a], exp_cpu_addr, exp_mem[a]);
                end
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        nRESET = 1'b0;
        REN_REQ = 1'b0;
        REN_ADDR = '0;
        CPU_ADDR_LD = 1'b0;
        CPU_ADDR_IN = '0;
        CPU_MOD = '0;
        CPU_REQ = 1'b0;
        CPU_WR = 1'b0;
        CPU_WDATA = '0;
        exp_cpu_addr = '0;
        mem_seed = 16'($urandom);
        for (int i = 0; i < 2048; i++) exp_mem[i] = fill_value(i);
        fork
            protocol_monitor();
        join_none
        test_reset();
        test_cpu_write();
        test_render_read();
        test_wrap_load();
        test_starvation();
        test_back_to_back();
        test_random();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
